// File: rtl/minn_pkg.sv
// Shared types for the Minn gate-and-peak tracker: FSM state encoding and
// the event record carried through the event queue.
package minn_pkg;

  // Default field widths of the event record; the tracker's width parameters
  // default to these so the record and the ports line up.
  localparam int MINN_METRIC_W = 36;
  localparam int MINN_ADDR_W   = 12;
  localparam int MINN_CNT_W    = 8;

  typedef enum logic [1:0] {
    GATE_IDLE    = 2'd0,
    GATE_OPEN    = 2'd1,
    GATE_CLOSING = 2'd2,
    GATE_HOLDOFF = 2'd3
  } gate_state_e;

  typedef struct packed {
    logic [MINN_ADDR_W-1:0]   addr;
    logic [MINN_METRIC_W-1:0] peak;
    logic [MINN_CNT_W-1:0]    width;
    logic                     truncated;
  } minn_evt_t;

endpackage

// File: rtl/minn_evt_fifo.sv
// Small event queue built as a shifting register file: entry 0 is always the
// head, so the pop-side data comes straight from flops. A push and a pop in
// the same cycle are both accepted even when the queue is full.
module minn_evt_fifo #(
  parameter int DATA_WIDTH = 57,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_ready_i,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      wr_idx;
  logic                  pop, push_ok;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign pop        = !empty_o && pop_ready_i;
  assign push_ok    = push_i && (!full_o || pop);
  // After a pop everything moves down one slot, so the new entry lands one lower.
  assign wr_idx     = count_q - CNT_W'(pop);
  assign pop_data_o = mem_q[0];

  // Next-state of the queue contents and occupancy.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    mem_d   = mem_q;
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
    end
    if (push_ok) begin
      mem_d[wr_idx[IDX_W-1:0]] = push_data_i;
    end
  end

  // Queue storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is reset (unlike a RAM) because entry 0 drives the
      // event outputs directly and those must read zero out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/minn_gate_peak_tracker.sv
// Gate-and-peak detector for the Minn preamble path. While the threshold gate
// is open it tracks the largest metric and its buffer address; the gate closes
// after a run-time hysteresis of below-threshold samples or when a maximum
// width is hit. Qualified detections go to a small event queue, followed by an
// optional holdoff during which the comparator is ignored.
module minn_gate_peak_tracker
  import minn_pkg::*;
#(
  parameter int METRIC_WIDTH  = MINN_METRIC_W,
  parameter int ADDR_WIDTH    = MINN_ADDR_W,
  parameter int CNT_WIDTH     = MINN_CNT_W,
  parameter int FIFO_DEPTH    = 4,
  parameter int TIMING_OFFSET = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_enable,
  input  logic [CNT_WIDTH-1:0]    cfg_hysteresis,
  input  logic [CNT_WIDTH-1:0]    cfg_min_width,
  input  logic [CNT_WIDTH-1:0]    cfg_max_width,
  input  logic [CNT_WIDTH-1:0]    cfg_holdoff,
  input  logic                    metric_valid,
  input  logic                    above_threshold,
  input  logic [METRIC_WIDTH-1:0] metric_value,
  input  logic [ADDR_WIDTH-1:0]   current_wptr,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [ADDR_WIDTH-1:0]   evt_addr,
  output logic [METRIC_WIDTH-1:0] evt_peak,
  output logic [CNT_WIDTH-1:0]    evt_width,
  output logic                    evt_truncated,
  output logic [15:0]             overflow_count,
  output logic                    busy
);

  // The offset is folded into the address width, so negative offsets wrap.
  localparam logic [ADDR_WIDTH-1:0] ADDR_OFFSET = ADDR_WIDTH'(TIMING_OFFSET);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE     = CNT_WIDTH'(1);

  gate_state_e             state_q, state_d;
  logic [METRIC_WIDTH-1:0] peak_q, peak_d;
  logic [ADDR_WIDTH-1:0]   peak_wptr_q, peak_wptr_d;
  logic [CNT_WIDTH-1:0]    width_q, width_d;
  logic [CNT_WIDTH-1:0]    hyst_q, hyst_d;
  logic [CNT_WIDTH-1:0]    hold_q, hold_d;
  logic [CNT_WIDTH-1:0]    width_inc;
  logic [15:0]             overflow_q;
  logic                    close_gate, close_trunc;
  logic                    evt_push, evt_drop, evt_pop;
  logic                    fifo_full, fifo_empty;
  minn_evt_t               push_evt, head_evt;

  // Width counter saturates instead of wrapping on very long gates.
  assign width_inc = (width_q == '1) ? width_q : width_q + CNT_ONE;

  // Gate FSM next-state, peak tracking and close decision.
  always_comb begin
    state_d     = state_q;
    peak_d      = peak_q;
    peak_wptr_d = peak_wptr_q;
    width_d     = width_q;
    hyst_d      = hyst_q;
    hold_d      = hold_q;
    close_gate  = 1'b0;
    close_trunc = 1'b0;
    evt_push    = 1'b0;

    if (!cfg_enable) begin
      // Disabling abandons any gate in progress; queued events are untouched.
      state_d = GATE_IDLE;
    end else if (metric_valid) begin
      unique case (state_q)
        GATE_IDLE: begin
          if (above_threshold) begin
            state_d     = GATE_OPEN;
            peak_d      = metric_value;
            peak_wptr_d = current_wptr;
            width_d     = CNT_ONE;
          end
        end
        GATE_OPEN, GATE_CLOSING: begin
          if (above_threshold) begin
            state_d = GATE_OPEN;
            width_d = width_inc;
            // Strict compare: on a tie the earliest sample keeps the peak.
            if (metric_value > peak_q) begin
              peak_d      = metric_value;
              peak_wptr_d = current_wptr;
            end
            if ((cfg_max_width != '0) && (width_inc == cfg_max_width)) begin
              close_gate  = 1'b1;
              close_trunc = 1'b1;
            end
          end else if (state_q == GATE_OPEN) begin
            state_d = GATE_CLOSING;
            hyst_d  = cfg_hysteresis;
          end else if (hyst_q != '0) begin
            hyst_d = hyst_q - CNT_ONE;
          end else begin
            close_gate = 1'b1;
          end
        end
        GATE_HOLDOFF: begin
          // Comparator ignored; hold is never zero while in this state.
          if (hold_q <= CNT_ONE) begin
            hold_d  = '0;
            state_d = GATE_IDLE;
          end else begin
            hold_d = hold_q - CNT_ONE;
          end
        end
        default: state_d = GATE_IDLE;
      endcase

      if (close_gate) begin
        if (width_d >= cfg_min_width) begin
          evt_push = 1'b1;
          hold_d   = cfg_holdoff;
          state_d  = (cfg_holdoff == '0) ? GATE_IDLE : GATE_HOLDOFF;
        end else begin
          state_d = GATE_IDLE;
        end
      end
    end
  end

  // Event record built from the values the closing sample produces.
  always_comb begin
    push_evt.addr      = peak_wptr_d + ADDR_OFFSET;
    push_evt.peak      = peak_d;
    push_evt.width     = width_d;
    push_evt.truncated = close_trunc;
  end

  // Gate FSM and tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= GATE_IDLE;
      peak_q      <= '0;
      peak_wptr_q <= '0;
      width_q     <= '0;
      hyst_q      <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      peak_q      <= peak_d;
      peak_wptr_q <= peak_wptr_d;
      width_q     <= width_d;
      hyst_q      <= hyst_d;
      hold_q      <= hold_d;
    end
  end

  assign evt_pop  = !fifo_empty && evt_ready;
  assign evt_drop = evt_push && fifo_full && !evt_pop;

  // Saturating count of events lost to a full queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= '0;
    end else if (evt_drop && (overflow_q != 16'hFFFF)) begin
      overflow_q <= overflow_q + 16'd1;
    end
  end

  minn_evt_fifo #(
    .DATA_WIDTH ($bits(minn_evt_t)),
    .DEPTH      (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (evt_push),
    .push_data_i (push_evt),
    .pop_ready_i (evt_ready),
    .pop_data_o  (head_evt),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign evt_valid      = !fifo_empty;
  assign evt_addr       = head_evt.addr;
  assign evt_peak       = head_evt.peak;
  assign evt_width      = head_evt.width;
  assign evt_truncated  = head_evt.truncated;
  assign overflow_count = overflow_q;
  assign busy           = (state_q != GATE_IDLE);

endmodule

// File: tb/tb_minn_gate_peak_tracker.sv
// Directed bench for minn_gate_peak_tracker (TIMING_OFFSET = -3, FIFO_DEPTH = 4).
module tb_minn_gate_peak_tracker;

  logic        clk, rst_n;
  logic        cfg_enable;
  logic [7:0]  cfg_hysteresis, cfg_min_width, cfg_max_width, cfg_holdoff;
  logic        metric_valid, above_threshold;
  logic [35:0] metric_value;
  logic [11:0] current_wptr;
  logic        evt_valid, evt_ready;
  logic [11:0] evt_addr;
  logic [35:0] evt_peak;
  logic [7:0]  evt_width;
  logic        evt_truncated;
  logic [15:0] overflow_count;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // {valid, truncated, width, addr, peak}
  logic [57:0] got;
  logic [57:0] exp;
  assign got = {evt_valid, evt_truncated, evt_width, evt_addr, evt_peak};

  minn_gate_peak_tracker #(
    .METRIC_WIDTH  (36),
    .ADDR_WIDTH    (12),
    .CNT_WIDTH     (8),
    .FIFO_DEPTH    (4),
    .TIMING_OFFSET (-3)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_enable      (cfg_enable),
    .cfg_hysteresis  (cfg_hysteresis),
    .cfg_min_width   (cfg_min_width),
    .cfg_max_width   (cfg_max_width),
    .cfg_holdoff     (cfg_holdoff),
    .metric_valid    (metric_valid),
    .above_threshold (above_threshold),
    .metric_value    (metric_value),
    .current_wptr    (current_wptr),
    .evt_valid       (evt_valid),
    .evt_ready       (evt_ready),
    .evt_addr        (evt_addr),
    .evt_peak        (evt_peak),
    .evt_width       (evt_width),
    .evt_truncated   (evt_truncated),
    .overflow_count  (overflow_count),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [57:0] pack(input logic v, input logic t, input logic [7:0] w,
                                       input logic [11:0] a, input logic [35:0] p);
    return {v, t, w, a, p};
  endfunction

  // One valid sample, presented at the falling edge; returns 1 unit after the
  // rising edge that consumed it.
  task automatic drive(input logic a, input logic [35:0] m, input logic [11:0] w, input logic rdy);
    @(negedge clk);
    metric_valid = 1'b1; above_threshold = a; metric_value = m; current_wptr = w; evt_ready = rdy;
    @(posedge clk);
    #1;
    metric_valid = 1'b0; above_threshold = 1'b0; evt_ready = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk);
    evt_ready = 1'b1;
    @(posedge clk);
    #1;
    evt_ready = 1'b0;
  endtask

  task automatic set_cfg(input logic [7:0] h, input logic [7:0] mn, input logic [7:0] mx, input logic [7:0] ho);
    cfg_hysteresis = h; cfg_min_width = mn; cfg_max_width = mx; cfg_holdoff = ho;
  endtask

  // Single above-threshold sample closed by two below samples (needs hysteresis 0).
  task automatic gen_event(input logic [35:0] m, input logic [11:0] w, input logic rdy_on_close);
    drive(1'b1, m, w, 1'b0);
    drive(1'b0, 36'd0, w + 12'd1, 1'b0);
    drive(1'b0, 36'd0, w + 12'd2, rdy_on_close);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_enable = 1'b1; set_cfg(8'd0, 8'd1, 8'd0, 8'd0);
    metric_valid = 1'b0; above_threshold = 1'b0; metric_value = '0; current_wptr = '0; evt_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (got !== 58'd0) begin bad++; $display("FAIL reset_evt got=%h want=0", got); end
    total++; if (overflow_count !== 16'd0) begin bad++; $display("FAIL reset_ovf got=%0d want=0", overflow_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_hysteresis();
    set_cfg(8'd2, 8'd1, 8'd0, 8'd0);
    drive(1'b1, 36'd5, 12'd10, 1'b0);
    drive(1'b1, 36'd9, 12'd11, 1'b0);
    drive(1'b1, 36'd7, 12'd12, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 36'd0, 12'd13 + 12'(i), 1'b0);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL t1_early got=%b want=0", evt_valid); end
    drive(1'b0, 36'd0, 12'd16, 1'b0);
    exp = pack(1'b1, 1'b0, 8'd3, 12'd8, 36'd9);
    total++; if (got !== exp) begin bad++; $display("FAIL t1_event got=%h want=%h", got, exp); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t1_busy got=%b want=0", busy); end
    pop_one();
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL t1_pop got=%b want=0", evt_valid); end
  endtask

  task automatic test_reopen();
    set_cfg(8'd1, 8'd1, 8'd0, 8'd0);
    drive(1'b1, 36'd3, 12'd20, 1'b0);
    drive(1'b1, 36'd4, 12'd21, 1'b0);
    drive(1'b0, 36'd0, 12'd22, 1'b0);
    drive(1'b1, 36'd8, 12'd23, 1'b0);
    drive(1'b0, 36'd0, 12'd24, 1'b0);
    drive(1'b0, 36'd0, 12'd25, 1'b0);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL t2_early got=%b want=0", evt_valid); end
    drive(1'b0, 36'd0, 12'd26, 1'b0);
    exp = pack(1'b1, 1'b0, 8'd3, 12'd20, 36'd8);
    total++; if (got !== exp) begin bad++; $display("FAIL t2_event got=%h want=%h", got, exp); end
    pop_one();
  endtask

  task automatic test_min_width();
    set_cfg(8'd0, 8'd4, 8'd0, 8'd0);
    for (int i = 0; i < 3; i++) drive(1'b1, 36'd5, 12'd30 + 12'(i), 1'b0);
    drive(1'b0, 36'd0, 12'd33, 1'b0);
    drive(1'b0, 36'd0, 12'd34, 1'b0);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL t3_short_evt got=%b want=0", evt_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t3_short_busy got=%b want=0", busy); end
    drive(1'b1, 36'd10, 12'd40, 1'b0);
    drive(1'b1, 36'd10, 12'd41, 1'b0);
    drive(1'b1, 36'd12, 12'd42, 1'b0);
    drive(1'b1, 36'd12, 12'd43, 1'b0);
    drive(1'b0, 36'd0, 12'd44, 1'b0);
    drive(1'b0, 36'd0, 12'd45, 1'b0);
    exp = pack(1'b1, 1'b0, 8'd4, 12'd39, 36'd12);
    total++; if (got !== exp) begin bad++; $display("FAIL t3_event got=%h want=%h", got, exp); end
    pop_one();
  endtask

  task automatic test_max_width_holdoff();
    logic [35:0] m [5];
    m[0] = 36'd6; m[1] = 36'd7; m[2] = 36'd9; m[3] = 36'd2; m[4] = 36'd3;
    set_cfg(8'd0, 8'd1, 8'd5, 8'd3);
    for (int i = 0; i < 4; i++) drive(1'b1, m[i], 12'(i), 1'b0);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL t4_early got=%b want=0", evt_valid); end
    drive(1'b1, m[4], 12'd4, 1'b0);
    // peak 9 at wptr 2, offset -3 wraps to 4095
    exp = pack(1'b1, 1'b1, 8'd5, 12'd4095, 36'd9);
    total++; if (got !== exp) begin bad++; $display("FAIL t4_event got=%h want=%h", got, exp); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL t4_hold_busy got=%b want=1", busy); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 36'd50, 12'd5 + 12'(i), 1'b0);
      total++;
      if (busy !== (i < 2)) begin bad++; $display("FAIL t4_hold%0d got=%b want=%b", i, busy, (i < 2)); end
    end
    pop_one();
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL t4_noextra got=%b want=0", evt_valid); end
  endtask

  task automatic test_overflow_drain();
    logic [35:0] pk [4];
    logic [11:0] ad [4];
    set_cfg(8'd0, 8'd1, 8'd0, 8'd0);
    for (int k = 0; k < 6; k++) gen_event(36'(k + 1), 12'(100 + 4 * k), 1'b0);
    exp = pack(1'b1, 1'b0, 8'd1, 12'd97, 36'd1);
    total++; if (got !== exp) begin bad++; $display("FAIL t5_head got=%h want=%h", got, exp); end
    total++; if (overflow_count !== 16'd2) begin bad++; $display("FAIL t5_ovf got=%0d want=2", overflow_count); end
    // Close of the 7th event coincides with a pop of the full queue.
    gen_event(36'd7, 12'd130, 1'b1);
    total++; if (overflow_count !== 16'd2) begin bad++; $display("FAIL t5_ovf_pp got=%0d want=2", overflow_count); end
    pk[0] = 36'd2; pk[1] = 36'd3; pk[2] = 36'd4; pk[3] = 36'd7;
    ad[0] = 12'd101; ad[1] = 12'd105; ad[2] = 12'd109; ad[3] = 12'd127;
    for (int i = 0; i < 4; i++) begin
      exp = pack(1'b1, 1'b0, 8'd1, ad[i], pk[i]);
      total++; if (got !== exp) begin bad++; $display("FAIL t5_drain%0d got=%h want=%h", i, got, exp); end
      pop_one();
    end
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL t5_empty got=%b want=0", evt_valid); end
  endtask

  task automatic test_async_reset_enable();
    set_cfg(8'd0, 8'd1, 8'd0, 8'd0);
    gen_event(36'd50, 12'd200, 1'b0);
    drive(1'b1, 36'd60, 12'd210, 1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL t6_open got=%b want=1", busy); end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++; if (got !== 58'd0) begin bad++; $display("FAIL t6_rst_evt got=%h want=0", got); end
    total++; if (overflow_count !== 16'd0) begin bad++; $display("FAIL t6_rst_ovf got=%0d want=0", overflow_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t6_rst_busy got=%b want=0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 36'd0, 12'd211, 1'b0);
    drive(1'b0, 36'd0, 12'd212, 1'b0);
    total++; if (evt_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL t6_post_rst got=%b%b want=00", evt_valid, busy);
    end
    gen_event(36'd70, 12'd300, 1'b0);
    drive(1'b1, 36'd80, 12'd310, 1'b0);
    @(negedge clk);
    cfg_enable = 1'b0;
    @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t6_disable got=%b want=0", busy); end
    cfg_enable = 1'b1;
    drive(1'b0, 36'd0, 12'd311, 1'b0);
    drive(1'b0, 36'd0, 12'd312, 1'b0);
    exp = pack(1'b1, 1'b0, 8'd1, 12'd297, 36'd70);
    total++; if (got !== exp) begin bad++; $display("FAIL t6_retained got=%h want=%h", got, exp); end
    pop_one();
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL t6_final got=%b want=0", evt_valid); end
  endtask

  initial begin
    test_reset();
    test_basic_hysteresis();
    test_reopen();
    test_min_width();
    test_max_width_holdoff();
    test_overflow_drain();
    test_async_reset_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
